// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the spi_module request arbiter.
// DEF_DATA_W/DEF_CFG_W must track the spi_module build.
package spi_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CFG_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } spi_arb_state_t;

    // Watchdog counter width: enough to hold TIMEOUT, never narrower than one bit.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Rotate-priority one-hot arbiter: the search starts just after last_grant_i
// and wraps modulo N_REQ. Purely combinational.
module spi_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_grant_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o,
    output logic                     valid_o
);

    localparam int IDX_W = $clog2(N_REQ);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                found         = 1'b1;
            end
        end
    end

    assign valid_o = found;

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one spi_module master among N_REQ requesters: round-robin accept,
// single outstanding transfer, watchdog-bounded wait for the SPI interrupt.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CFG_W   = DEF_CFG_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic [N_REQ*CFG_W-1:0]    i_req_cfg,
    output logic [N_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_err,
    output logic [DATA_W-1:0]         o_spi_data,
    output logic [CFG_W-1:0]          o_spi_cfg,
    output logic                      o_spi_trans_en,
    input  logic                      i_spi_interrupt,
    input  logic [DATA_W-1:0]         i_spi_rdata,
    output logic                      o_busy,
    output logic [$clog2(N_REQ)-1:0]  o_grant_id
);

    localparam int               IDX_W     = $clog2(N_REQ);
    localparam int               CNT_W     = wdog_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam bit               WDOG_EN   = (TIMEOUT != 0);

    spi_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  spi_data_q, spi_data_d;
    logic [CFG_W-1:0]   spi_cfg_q, spi_cfg_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               accept;

    logic [DATA_W-1:0]  req_data_arr [N_REQ];
    logic [CFG_W-1:0]   req_cfg_arr  [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = i_req_data[gi*DATA_W +: DATA_W];
            assign req_cfg_arr[gi]  = i_req_cfg[gi*CFG_W +: CFG_W];
        end
    endgenerate

    spi_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req_i        (i_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .valid_o      (arb_any)
    );

    // Ready is gated by reset so nothing can be accepted while the block is held.
    assign o_req_ready = (state_q == IDLE && i_sys_rst && arb_any) ? arb_grant : '0;
    assign accept      = |o_req_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        spi_data_d   = spi_data_q;
        spi_cfg_d    = spi_cfg_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        wdog_d       = wdog_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    spi_data_d   = req_data_arr[arb_idx];
                    spi_cfg_d    = req_cfg_arr[arb_idx];
                    grant_id_d   = arb_idx;
                    last_grant_d = arb_idx;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Interrupt takes precedence over a watchdog expiry in the same cycle.
                if (i_spi_interrupt) begin
                    rsp_data_d = i_spi_rdata;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (WDOG_EN && wdog_q == CNT_LIMIT) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else if (WDOG_EN && wdog_q != '1) begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(N_REQ - 1);
            grant_id_q   <= '0;
            spi_data_q   <= '0;
            spi_cfg_q    <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            spi_data_q   <= spi_data_d;
            spi_cfg_q    <= spi_cfg_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            wdog_q       <= wdog_d;
        end
    end

    assign o_spi_trans_en = (state_q == LAUNCH);
    assign o_busy         = (state_q != IDLE);
    assign o_rsp_valid    = (state_q == RESP) ? (N_REQ'(1) << grant_id_q) : '0;
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_err      = rsp_err_q;
    assign o_spi_data     = spi_data_q;
    assign o_spi_cfg      = spi_cfg_q;
    assign o_grant_id     = grant_id_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: directed vector table, hand sequences for
// round-robin / spurious / reset corners, then random traffic vs a cycle-rule model.
module tb_spi_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic [N*CW-1:0] req_cfg;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic [DW-1:0]   spi_data;
    logic [CW-1:0]   spi_cfg;
    logic            spi_trans_en;
    logic            spi_intr;
    logic [DW-1:0]   spi_rdata;
    logic            busy;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    spi_req_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .CFG_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .i_sys_clk       (clk),
        .i_sys_rst       (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_data      (req_data),
        .i_req_cfg       (req_cfg),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_data      (rsp_data),
        .o_rsp_err       (rsp_err),
        .o_spi_data      (spi_data),
        .o_spi_cfg       (spi_cfg),
        .o_spi_trans_en  (spi_trans_en),
        .i_spi_interrupt (spi_intr),
        .i_spi_rdata     (spi_rdata),
        .o_busy          (busy),
        .o_grant_id      (grant_id)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic [7:0] cfg;
        int         intr_cyc;     // -1: never
        logic [7:0] rdata;
        logic [3:0] exp_ready;
        int         exp_rsp_cyc;  // relative to accept
        logic [7:0] exp_rsp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        spi_intr  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_trans_en"}, 32'(spi_trans_en), 0);
        chk({tag, "_rsp_valid"},32'(rsp_valid), 0);
        chk({tag, "_rsp_err"},  32'(rsp_err), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 0);
        chk({tag, "_spi_data"}, 32'(spi_data), 0);
        chk({tag, "_spi_cfg"},  32'(spi_cfg), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        oh = 4'b0001 << v.req;
        step();
        req_valid = oh;
        req_data[v.req*DW +: DW] = v.data;
        req_cfg[v.req*CW +: CW]  = v.cfg;
        spi_intr = 1'b0;
        #1;
        chk("vec_ready", 32'(req_ready), 32'(v.exp_ready));
        step();
        req_valid = '0;
        #1;
        chk("vec_trans_en", 32'(spi_trans_en), 1);
        chk("vec_spi_data", 32'(spi_data), 32'(v.data));
        chk("vec_spi_cfg",  32'(spi_cfg), 32'(v.cfg));
        chk("vec_grant_id", 32'(grant_id), 32'(v.req));
        for (int c = 2; c <= v.exp_rsp_cyc; c++) begin
            step();
            spi_intr  = (c == v.intr_cyc);
            spi_rdata = v.rdata;
            #1;
            if (c == v.exp_rsp_cyc) begin
                chk("vec_rsp_valid", 32'(rsp_valid), 32'(oh));
                chk("vec_rsp_data",  32'(rsp_data), 32'(v.exp_rsp_data));
                chk("vec_rsp_err",   32'(rsp_err), 32'(v.exp_err));
                chk("vec_spi_hold",  32'(spi_data), 32'(v.data));
            end else begin
                chk("vec_no_early_rsp", 32'(rsp_valid), 0);
            end
        end
    endtask

    function automatic logic [3:0] rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return 4'b0001 << ((last + k) % N);
        end
        return 4'b0000;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
        $fatal(1);
    end

    initial begin
        int         exp_order [5];
        int         acc_prev;
        int         n;
        logic [3:0] vr;
        // random-phase model state
        bit         m_busy;
        int         m_acc, m_rsp, m_last, m_owner;
        logic [7:0] m_data, m_cfg, m_rdata;
        logic       m_err;
        logic [3:0] e_ready, e_rsp;

        vecs[0] = '{2, 8'hA5, 8'h03, 10, 8'h5A, 4'b0100, 11, 8'h5A, 1'b0};
        vecs[1] = '{0, 8'h3C, 8'h81,  2, 8'hC3, 4'b0001,  3, 8'hC3, 1'b0};
        vecs[2] = '{3, 8'h11, 8'h22, -1, 8'h77, 4'b1000, 19, 8'h00, 1'b1};
        vecs[3] = '{1, 8'h99, 8'h0F, 18, 8'h6B, 4'b0010, 19, 8'h6B, 1'b0};
        vecs[4] = '{2, 8'h00, 8'hFF, 17, 8'hE1, 4'b0100, 18, 8'hE1, 1'b0};
        exp_order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_cfg   = '0;
        spi_intr  = 1'b0;
        spi_rdata = '0;

        // Reset state; ready must stay low even with every requester valid.
        step();
        step();
        req_valid = 4'hF;
        #1;
        chk_reset_outputs("reset");
        chk("reset_ready_gated", 32'(req_ready), 0);
        req_valid = '0;
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Round-robin with all requesters valid, interrupt 3 cycles after trans_en.
        do_reset();
        for (int r = 0; r < N; r++) begin
            req_data[r*DW +: DW] = 8'h10 + 8'(r);
            req_cfg[r*CW +: CW]  = 8'h20 + 8'(r);
        end
        req_valid = 4'hF;
        #1;
        acc_prev = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (!(|(req_ready & req_valid)) && n < 20) begin
                step();
                #1;
                n++;
            end
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << exp_order[g]));
            if (g > 0) chk("rr_spacing", 32'(cyc - acc_prev), 6);
            acc_prev = cyc;
            step(); #1;
            chk("rr_spi_data", 32'(spi_data), 32'(8'h10 + 8'(exp_order[g])));
            step(); #1;
            step(); #1;
            step(); spi_intr = 1'b1; #1;
            step(); spi_intr = 1'b0; #1;
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << exp_order[g]));
        end
        req_valid = '0;

        // Spurious interrupt while idle.
        step(); spi_intr = 1'b1; #1;
        chk("spur_busy", 32'(busy), 0);
        step(); spi_intr = 1'b0; #1;
        chk("spur_no_rsp", 32'(rsp_valid), 0);
        step(); #1;
        chk("spur_no_rsp2", 32'(rsp_valid), 0);
        chk("spur_idle", 32'(busy), 0);

        // Reset while waiting for the SPI interrupt.
        step();
        req_valid = 4'b1000;
        req_data[3*DW +: DW] = 8'hC7;
        #1;
        chk("rstw_ready", 32'(req_ready), 32'(4'b1000));
        step(); req_valid = '0; #1;
        step(); #1;
        chk("rstw_busy", 32'(busy), 1);
        step(); rst_n = 1'b0; req_valid = 4'b1110; #1;
        chk("rstw_ready_low", 32'(req_ready), 0);
        step(); #1;
        chk_reset_outputs("rstw");
        step(); rst_n = 1'b1; req_valid = 4'hF; #1;
        chk("rstw_no_rsp", 32'(rsp_valid), 0);
        chk("rstw_first_grant", 32'(req_ready), 32'(4'b0001));
        step(); req_valid = '0; #1;
        step(); spi_intr = 1'b1; spi_rdata = 8'h3E; #1;
        step(); spi_intr = 1'b0; #1;
        chk("rstw_after_rsp", 32'(rsp_valid), 32'(4'b0001));
        chk("rstw_after_data", 32'(rsp_data), 32'(8'h3E));

        // Random traffic against a model driven by the cycle-count rules.
        do_reset();
        vr      = '0;
        m_busy  = 0;
        m_acc   = 0;
        m_rsp   = -1;
        m_last  = N - 1;
        m_owner = 0;
        m_data  = '0;
        m_cfg   = '0;
        m_rdata = '0;
        m_err   = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (t > 0) step();
            for (int r = 0; r < N; r++) begin
                if (!vr[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        vr[r] = 1'b1;
                        req_data[r*DW +: DW] = 8'($urandom);
                        req_cfg[r*CW +: CW]  = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    vr[r] = 1'b0;
                end
            end
            req_valid = vr;
            spi_intr  = ($urandom_range(0, 11) == 0);
            spi_rdata = 8'($urandom);
            #1;

            e_ready = m_busy ? 4'b0000 : rr_pick(vr, m_last);
            e_rsp   = (m_busy && m_rsp == cyc) ? (4'b0001 << m_owner) : 4'b0000;
            chk("rnd_ready",     32'(req_ready), 32'(e_ready));
            chk("rnd_busy",      32'(busy), 32'(m_busy));
            chk("rnd_trans_en",  32'(spi_trans_en), 32'(m_busy && cyc == m_acc + 1));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("rnd_spi_data",  32'(spi_data), 32'(m_data));
            chk("rnd_spi_cfg",   32'(spi_cfg), 32'(m_cfg));
            chk("rnd_grant_id",  32'(grant_id), 32'(m_owner));
            if (e_rsp != 0) begin
                chk("rnd_rsp_data", 32'(rsp_data), 32'(m_rdata));
                chk("rnd_rsp_err",  32'(rsp_err), 32'(m_err));
            end

            if (!m_busy) begin
                if (e_ready != 0) begin
                    for (int r = 0; r < N; r++) if (e_ready[r]) m_owner = r;
                    m_busy = 1;
                    m_acc  = cyc;
                    m_rsp  = -1;
                    m_last = m_owner;
                    m_data = req_data[m_owner*DW +: DW];
                    m_cfg  = req_cfg[m_owner*CW +: CW];
                    vr[m_owner] = 1'b0;
                end
            end else if (m_rsp == cyc) begin
                m_busy = 0;
            end else if (m_rsp < 0 && cyc >= m_acc + 2) begin
                if (spi_intr) begin
                    m_rsp   = cyc + 1;
                    m_rdata = spi_rdata;
                    m_err   = 1'b0;
                end else if (cyc == m_acc + 2 + TO) begin
                    m_rsp   = cyc + 1;
                    m_rdata = 8'h00;
                    m_err   = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
